// File: rtl/placar_pkg.sv
// Shared scoreboard types and constants for the shot-clock path.
package placar_pkg;

    typedef enum logic [1:0] {
        STOPPED,
        RUNNING,
        BUZZING,
        EXPIRED
    } shot_state_t;

    localparam int unsigned     SEC_W        = 5;
    localparam logic [SEC_W-1:0] SHOT_FULL    = 5'd24;
    localparam logic [SEC_W-1:0] SHOT_RESET14 = 5'd14;

endpackage

// File: rtl/shot_clock_controller_if.sv
// Operator controls in, shot-clock display/status out.
interface shot_clock_controller_if;
    import placar_pkg::*;

    logic             btn_reload24;
    logic             btn_reload14;
    logic             run;
    logic [SEC_W-1:0] seconds;
    logic             buzzer;
    logic             running;
    logic             expired;

    modport master (
        output btn_reload24, btn_reload14, run,
        input  seconds, buzzer, running, expired
    );

    modport slave (
        input  btn_reload24, btn_reload14, run,
        output seconds, buzzer, running, expired
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a registered level and a one-cycle rising-edge pulse.
module sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic level_q;
    logic rise_q;

    // level and rise are both registered so every consumer sees them in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            meta_q  <= din;
            sync_q  <= meta_q;
            level_q <= sync_q;
            rise_q  <= sync_q & ~level_q;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/shot_clock_controller.sv
// Regressive 24/14 s shot clock: synchronized controls, 1 Hz prescaler, reload rules, buzzer.
module shot_clock_controller
    import placar_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned BUZZ_CYCLES = 25_000_000
) (
    input logic                    clock,
    input logic                    reset,
    shot_clock_controller_if.slave bus
);

    localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BUZZ_W = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_CYCLES - 1);
    localparam logic [SEC_W-1:0]  ONE_SEC   = SEC_W'(1);

    logic run_s;
    logic rl24;
    logic rl14;
    logic unused_run_rise;
    logic unused_rl24_level;
    logic unused_rl14_level;

    sync_edge u_sync_rl24 (
        .clock (clock),
        .reset (reset),
        .din   (bus.btn_reload24),
        .level (unused_rl24_level),
        .rise  (rl24)
    );

    sync_edge u_sync_rl14 (
        .clock (clock),
        .reset (reset),
        .din   (bus.btn_reload14),
        .level (unused_rl14_level),
        .rise  (rl14)
    );

    sync_edge u_sync_run (
        .clock (clock),
        .reset (reset),
        .din   (bus.run),
        .level (run_s),
        .rise  (unused_run_rise)
    );

    shot_state_t       state_q;
    logic [SEC_W-1:0]  sec_q;
    logic              buzzer_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic [BUZZ_W-1:0] buzz_cnt_q;

    logic             tick;
    logic             reload;
    logic [SEC_W-1:0] reload_val;

    // A 14 s request only counts when it would raise the clock; 24 always wins.
    always_comb begin
        tick       = (state_q == RUNNING) && (div_cnt_q == DIV_LAST);
        reload     = rl24 || (rl14 && (sec_q < SHOT_RESET14));
        reload_val = rl24 ? SHOT_FULL : SHOT_RESET14;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= STOPPED;
            sec_q      <= SHOT_FULL;
            buzzer_q   <= 1'b0;
            div_cnt_q  <= '0;
            buzz_cnt_q <= '0;
        end else if (reload) begin
            sec_q      <= reload_val;
            state_q    <= run_s ? RUNNING : STOPPED;
            buzzer_q   <= 1'b0;
            div_cnt_q  <= '0;
            buzz_cnt_q <= '0;
        end else begin
            unique case (state_q)
                STOPPED: begin
                    div_cnt_q <= '0;
                    if (run_s && (sec_q != '0)) begin
                        state_q <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (!run_s) begin
                        state_q   <= STOPPED;
                        div_cnt_q <= '0;
                    end else if (tick) begin
                        div_cnt_q <= '0;
                        if (sec_q > ONE_SEC) begin
                            sec_q <= sec_q - ONE_SEC;
                        end else begin
                            sec_q      <= '0;
                            state_q    <= BUZZING;
                            buzzer_q   <= 1'b1;
                            buzz_cnt_q <= '0;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                BUZZING: begin
                    div_cnt_q <= '0;
                    if (buzz_cnt_q == BUZZ_LAST) begin
                        state_q    <= EXPIRED;
                        buzzer_q   <= 1'b0;
                        buzz_cnt_q <= '0;
                    end else begin
                        buzz_cnt_q <= buzz_cnt_q + BUZZ_W'(1);
                    end
                end
                EXPIRED: begin
                    div_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.seconds = sec_q;
    assign bus.buzzer  = buzzer_q;
    assign bus.running = (state_q == RUNNING);
    assign bus.expired = (state_q == BUZZING) || (state_q == EXPIRED);

endmodule

// File: tb/tb_shot_clock_controller.sv
// Directed and random stimulus against a cycle-level reference model of the shot clock.
module tb_shot_clock_controller;

    localparam int unsigned TD = 4;
    localparam int unsigned BC = 6;

    localparam int M_STOP = 0;
    localparam int M_RUN  = 1;
    localparam int M_BUZZ = 2;
    localparam int M_EXP  = 3;

    logic clock = 1'b0;
    logic reset;

    shot_clock_controller_if bus ();

    shot_clock_controller #(
        .TICK_DIV    (TD),
        .BUZZ_CYCLES (BC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: remaining time, mode, and the input samples taken at each edge.
    int m_sec;
    int m_mode;
    int m_since;
    int m_buzz_left;
    bit h_run [5];
    bit h_b24 [5];
    bit h_b14 [5];

    task automatic model_reset();
        m_sec       = 24;
        m_mode      = M_STOP;
        m_since     = 0;
        m_buzz_left = 0;
        for (int i = 0; i < 5; i++) begin
            h_run[i] = 1'b0;
            h_b24[i] = 1'b0;
            h_b14[i] = 1'b0;
        end
    endtask

    // Inputs sampled at edge n-3 (rise: n-3 high, n-4 low) act at edge n.
    task automatic model_step();
        bit r;
        bit a;
        bit b;
        r = h_run[3];
        a = h_b24[3] && !h_b24[4];
        b = h_b14[3] && !h_b14[4] && (m_sec < 14);
        if (a || b) begin
            m_sec       = a ? 24 : 14;
            m_mode      = r ? M_RUN : M_STOP;
            m_since     = 0;
            m_buzz_left = 0;
        end else begin
            case (m_mode)
                M_STOP: begin
                    if (r && m_sec != 0) begin
                        m_mode  = M_RUN;
                        m_since = 0;
                    end
                end
                M_RUN: begin
                    if (!r) begin
                        m_mode  = M_STOP;
                        m_since = 0;
                    end else begin
                        m_since++;
                        if (m_since == TD) begin
                            m_since = 0;
                            if (m_sec > 1) begin
                                m_sec--;
                            end else begin
                                m_sec       = 0;
                                m_mode      = M_BUZZ;
                                m_buzz_left = BC;
                            end
                        end
                    end
                end
                M_BUZZ: begin
                    m_buzz_left--;
                    if (m_buzz_left == 0) m_mode = M_EXP;
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 4; i > 0; i--) begin
                h_run[i] = h_run[i-1];
                h_b24[i] = h_b24[i-1];
                h_b14[i] = h_b14[i-1];
            end
            h_run[0] = bus.run;
            h_b24[0] = bus.btn_reload24;
            h_b14[0] = bus.btn_reload14;
            model_step();
        end
        #1;
        check("seconds", bus.seconds, m_sec);
        check("buzzer", bus.buzzer, (m_mode == M_BUZZ));
        check("running", bus.running, (m_mode == M_RUN));
        check("expired", bus.expired, (m_mode == M_BUZZ) || (m_mode == M_EXP));
    endtask

    task automatic wait_sec(input int target, input string tag);
        for (int i = 0; i < 400 && m_sec != target; i++) cycle();
        check(tag, bus.seconds, target);
    endtask

    task automatic wait_buzz(input string tag);
        for (int i = 0; i < 400 && m_mode != M_BUZZ; i++) cycle();
        check(tag, bus.buzzer, 1);
    endtask

    task automatic pulse(input bit b24, input bit b14);
        bus.btn_reload24 = b24;
        bus.btn_reload14 = b14;
        cycle();
        cycle();
        bus.btn_reload24 = 1'b0;
        bus.btn_reload14 = 1'b0;
    endtask

    task automatic reset_async(input string tag);
        #1;
        reset = 1'b1;
        #1;
        check({tag, "_sec"}, bus.seconds, 24);
        check({tag, "_buzz"}, bus.buzzer, 0);
        check({tag, "_run"}, bus.running, 0);
        check({tag, "_exp"}, bus.expired, 0);
        model_reset();
        repeat (3) cycle();
        reset = 1'b0;
    endtask

    int nb;

    initial begin
        reset            = 1'b1;
        bus.btn_reload24 = 1'b0;
        bus.btn_reload14 = 1'b0;
        bus.run          = 1'b1;
        model_reset();
        #1;
        check("rst_sec", bus.seconds, 24);
        check("rst_running", bus.running, 0);
        check("rst_expired", bus.expired, 0);
        repeat (2) cycle();
        reset = 1'b0;

        // Power-up countdown with run held high.
        repeat (7) cycle();
        check("hold24", bus.seconds, 24);
        cycle();
        check("first_dec", bus.seconds, 23);

        wait_buzz("buzz_start");
        check("buzz_sec0", bus.seconds, 0);
        check("buzz_expired", bus.expired, 1);
        nb = 0;
        for (int i = 0; i < 20 && bus.buzzer; i++) begin
            nb++;
            cycle();
        end
        check("buzz_len", nb, BC);
        repeat (5) cycle();
        check("exp_sec0", bus.seconds, 0);
        check("exp_flag", bus.expired, 1);

        // 14 s rule: ignored at 20, applied at 9.
        pulse(1'b1, 1'b0);
        wait_sec(20, "at20");
        pulse(1'b0, 1'b1);
        repeat (4) cycle();
        wait_sec(9, "at9");
        pulse(1'b0, 1'b1);
        for (int i = 0; i < 10 && bus.seconds != 14; i++) cycle();
        check("rl14_val", bus.seconds, 14);
        nb = 0;
        for (int i = 0; i < 10 && bus.seconds == 14; i++) begin
            cycle();
            nb++;
        end
        check("rl14_next_dec", nb, TD);
        check("rl14_13", bus.seconds, 13);

        // Simultaneous buttons: 24 wins.
        wait_sec(5, "at5");
        pulse(1'b1, 1'b1);
        repeat (2) cycle();
        check("both_rl24", bus.seconds, 24);

        // Reload during the buzz.
        wait_buzz("buzz2_start");
        bus.btn_reload24 = 1'b1;
        repeat (4) cycle();
        bus.btn_reload24 = 1'b0;
        check("buzz_rl_buzzer", bus.buzzer, 0);
        check("buzz_rl_sec", bus.seconds, 24);
        check("buzz_rl_running", bus.running, 1);

        // Pause and resume.
        wait_sec(17, "at17");
        bus.run = 1'b0;
        repeat (10) cycle();
        check("pause_sec", bus.seconds, 17);
        check("pause_running", bus.running, 0);
        bus.run = 1'b1;
        for (int i = 0; i < 10 && !bus.running; i++) cycle();
        check("resume_running", bus.running, 1);
        nb = 0;
        for (int i = 0; i < 10 && bus.seconds == 17; i++) begin
            cycle();
            nb++;
        end
        check("resume_dec", nb, TD);

        // Reset in the middle of a buzz.
        wait_buzz("buzz3_start");
        repeat (2) cycle();
        reset_async("midbuzz");

        // Random operation.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(39) == 0) bus.run = ~bus.run;
            if ($urandom_range(59) == 0) bus.btn_reload24 = 1'b1;
            else if ($urandom_range(2) == 0) bus.btn_reload24 = 1'b0;
            if ($urandom_range(14) == 0) bus.btn_reload14 = 1'b1;
            else if ($urandom_range(2) == 0) bus.btn_reload14 = 1'b0;
            if ($urandom_range(999) == 0) reset_async("rand_rst");
            else cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shot_clock_controller.md
# shot_clock_controller

Sequencing controller for the scoreboard's regressive shot clock. Owns the 24/14-second possession count, its run/stop control, reload rules and buzzer timing, and produces the 5-bit seconds value consumed by the binary-to-BCD converter and display path. It derives its own 1 Hz decrement tick from the board clock and replaces ad-hoc switch handling with synchronized, edge-detected commands.

## Interface

**Parameters**
- `TICK_DIV`, default 50_000_000: clock cycles per decrement tick (1 Hz at 50 MHz).
- `BUZZ_CYCLES`, default 25_000_000: buzzer-on duration in clock cycles.

**Ports** (clock and reset first)
- `clock` input 1: system clock; every register is on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `btn_reload24` input 1: raw level; a rising edge requests a reload to 24.
- `btn_reload14` input 1: raw level; a rising edge requests the 14-second rule.
- `run` input 1: raw level; high = count, low = stopped.
- `seconds` output 5: current shot-clock value, 0..24.
- `buzzer` output 1: high while the expiry buzzer sounds.
- `running` output 1: high in RUNNING.
- `expired` output 1: high in BUZZING and EXPIRED.

## Operation

- All three inputs pass through a 2-flop synchronizer. The two buttons also get a rising-edge detector that gives a 1-cycle pulse (`rl24`, `rl14`). `run_s` is the synchronized level.
- Prescaler `div_cnt` counts 0..`TICK_DIV`-1 while in RUNNING. `tick` = the cycle in which `div_cnt == TICK_DIV-1`. The prescaler is cleared in every other state and on any reload.

**FSM states**
- STOPPED: `seconds` held.
- RUNNING: `seconds` decrements on `tick`.
- BUZZING: `seconds` = 0, `buzzer` = 1, buzz counter runs.
- EXPIRED: `seconds` = 0, `buzzer` = 0, waits for a reload.

**Transitions**
- STOPPED -> RUNNING when `run_s`=1 and `seconds` != 0.
- RUNNING -> STOPPED when `run_s`=0. The partial prescaler count is discarded.
- RUNNING, `tick`, `seconds` > 1: decrement.
- RUNNING, `tick`, `seconds` == 1: set `seconds` = 0 and go to BUZZING.
- BUZZING -> EXPIRED after `BUZZ_CYCLES` cycles. `run_s` is ignored in BUZZING and EXPIRED.

**Reload rules** (apply in every state; they take priority over `tick` in the same cycle)
- `rl24`: `seconds` <= 24.
- `rl14`: `seconds` <= 14 only if `seconds` < 14; otherwise no change and no state change.
- `rl24` and `rl14` in the same cycle: `rl24` wins.
- After an effective reload: next state is RUNNING if `run_s`=1, else STOPPED. A reload during BUZZING drops `buzzer` immediately and clears the buzz counter.

**Arithmetic and width**
- `seconds` is unsigned 5-bit. It never wraps below 0 or exceeds 24.
- The buzz counter and `div_cnt` are sized with $clog2 of their parameter.

## Timing

- Reset values: `seconds`=24, state STOPPED, `buzzer`=0, `running`=0, `expired`=0. Synchronizers, edge detectors and counters are all 0.
- Reset asserted mid-operation (including mid-buzz) forces the reset values asynchronously. After release, the synchronized inputs must be re-observed before any action.
- Input latency: a button rising edge first seen at clock edge k changes `seconds` at edge k+3. `run` changes `running` at edge k+3.
- First decrement after entering RUNNING (or after a reload while running): `TICK_DIV` cycles later.
- Outputs are registered, or decoded directly from registered state; there are no combinational paths from inputs to outputs.
- `buzzer` is high for exactly `BUZZ_CYCLES` cycles unless it is cut short by a reload or reset.

## Structure

- Shared package `placar_pkg` holds:
  - state enum `shot_state_t` {STOPPED, RUNNING, BUZZING, EXPIRED};
  - constants `SHOT_FULL`=24 and `SHOT_RESET14`=14;
  - `SEC_W`=5.
- Sub-module `sync_edge` (2-flop synchronizer + rising-edge pulse, with a `level` and a `rise` output) is instantiated three times. For `run`, only the level output is used.

## Test plan

All scenarios use `TICK_DIV`=4 and `BUZZ_CYCLES`=6.

- Reset release, `run`=1: `seconds`=24 for the first 3+4 cycles, then decrements every 4 cycles: 23, 22, ….
- Count from 24 to 0: the 1->0 step asserts `buzzer`=1 and `expired`=1. `buzzer` falls after exactly 6 cycles, `seconds` stays 0 and `expired` stays 1 with `run` still high.
- `seconds`=20, pulse `btn_reload14`: no change. Then at `seconds`=9, pulse `btn_reload14`: `seconds`=14, and the next decrement follows 4 cycles later.
- Raise both buttons in the same cycle at `seconds`=5: `seconds`=24 (24-reload wins).
- `btn_reload24` raised during cycle 2 of the buzz: `buzzer` drops on the reload cycle, `seconds`=24, state RUNNING.
- `run` low mid-count at `seconds`=17, then high again after 10 cycles: `seconds` holds 17, then decrements 4 cycles after `running` re-asserts. Asserting `reset` mid-buzz gives `seconds`=24 and `buzzer`=0 immediately.
